// File: rtl/tri_fetch_pkg.sv
// Shared types and defaults for the triangle element fetch sequencer.
//   tri_fetch_state_t : sweep FSM states
//   tri_fetch_entry_t : one output FIFO entry {data, index, last}
package tri_fetch_pkg;

  localparam int unsigned NDWORDS_DEFAULT    = 9;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
  localparam int unsigned ELEMSZ_DEFAULT     = 32 * NDWORDS_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } tri_fetch_state_t;

  typedef struct packed {
    logic [ELEMSZ_DEFAULT-1:0] data;
    logic [31:0]               index;
    logic                      last;
  } tri_fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered head.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write strobe and data (caller guarantees space)
//   pop         : remove head (ignored when empty)
//   head        : registered head entry (stale when count == 0)
//   count       : current occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;

  assign do_pop     = pop && (count != '0);
  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign head       = head_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr_nxt;
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
      // Head follows the new entry when it becomes the only one; otherwise
      // it advances to the next stored entry on a pop.
      if (push && (count == '0 || (do_pop && count == CW'(1))))
        head_q <= din;
      else if (do_pop && count > CW'(1))
        head_q <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/tri_fetch_seq.sv
// Sweeps element indices first_index..first_index+count-1, reads each one
// from the cached element reader, and forwards it downstream via a FIFO.
//   start/first_index/count : sweep command (sampled in IDLE only)
//   busy, done              : status; done pulses once the FIFO drains
//   rd_*                    : single-outstanding request to the reader
//   out_*                   : valid/ready element stream with index and last
module tri_fetch_seq
  import tri_fetch_pkg::*;
#(
  parameter  int unsigned NDWORDS    = NDWORDS_DEFAULT,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned ELEMSZ     = 32 * NDWORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       first_index,
  input  logic [31:0]       count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rd_index,
  output logic              rd_read,
  input  logic              rd_iready,
  input  logic [ELEMSZ-1:0] rd_data,
  input  logic              rd_ovalid,
  output logic [ELEMSZ-1:0] out_data,
  output logic [31:0]       out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ELEMSZ-1:0] data;
    logic [31:0]       index;
    logic              last;
  } entry_t;

  tri_fetch_state_t state, state_nxt;
  logic [31:0]      cur_idx;
  logic [31:0]      remaining;
  logic             done_q, done_nxt;
  logic             load, capture;
  logic [CW-1:0]    fifo_count;
  logic             fifo_pop;
  logic             room;
  entry_t           push_entry, head_entry;

  // A request is only issued while a FIFO slot is free for its response.
  assign room      = fifo_count < CW'(FIFO_DEPTH);
  assign out_valid = fifo_count != '0;
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    rd_read   = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (count == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_iready && room) begin
          rd_read   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_ovalid) begin
          capture   = 1'b1;
          state_nxt = (remaining > 32'd1) ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Looks ahead to the pop of the final entry so done lands one
        // cycle after that pop.
        if (fifo_count == '0 || (fifo_count == CW'(1) && fifo_pop)) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (load) begin
        cur_idx   <= first_index;
        remaining <= count;
      end else if (capture) begin
        cur_idx   <= cur_idx + 32'd1;
        remaining <= remaining - 32'd1;
      end
    end
  end

  assign push_entry = '{data: rd_data, index: cur_idx, last: (remaining == 32'd1)};

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (capture),
    .din   (push_entry),
    .pop   (fifo_pop),
    .head  (head_entry),
    .count (fifo_count)
  );

  assign busy      = state != ST_IDLE;
  assign done      = done_q;
  assign rd_index  = cur_idx;
  assign out_data  = head_entry.data;
  assign out_index = head_entry.index;
  assign out_last  = head_entry.last;

endmodule

// File: tb/tb_tri_fetch_seq.sv
module tb_tri_fetch_seq;

  localparam int unsigned NDWORDS    = 9;
  localparam int unsigned ELEMSZ     = 32 * NDWORDS;
  localparam int unsigned FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       first_index = '0;
  logic [31:0]       count = '0;
  logic              busy, done, rd_read;
  logic [31:0]       rd_index;
  logic              rd_iready = 1'b1;
  logic [ELEMSZ-1:0] rd_data;
  logic              rd_ovalid;
  logic [ELEMSZ-1:0] out_data;
  logic [31:0]       out_index;
  logic              out_last, out_valid;
  logic              out_ready = 1'b1;

  tri_fetch_seq #(.NDWORDS(NDWORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .first_index(first_index),
    .count(count), .busy(busy), .done(done), .rd_index(rd_index),
    .rd_read(rd_read), .rd_iready(rd_iready), .rd_data(rd_data),
    .rd_ovalid(rd_ovalid), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int req_total = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rd_read === 1'b1) req_total <= req_total + 1;

  // Reader model: answers each request after rdr_delay cycles
  // (rdr_miss_delay for request number rdr_miss_at).
  int          rdr_delay = 1;
  int          rdr_miss_at = 0;
  int          rdr_miss_delay = 1;
  int          rdr_nreq = 0;
  logic [31:0] salt = 32'h1234_5678;

  function automatic logic [ELEMSZ-1:0] elem_of(input logic [31:0] idx);
    logic [ELEMSZ-1:0] v;
    for (int unsigned w = 0; w < NDWORDS; w++)
      v[w*32 +: 32] = (idx * 32'h9E37_79B1) ^ (w * 32'h0101_0101) ^ salt;
    return v;
  endfunction

  initial begin : reader
    int d;
    logic [31:0] idx;
    rd_ovalid = 1'b0;
    rd_data   = '0;
    forever begin
      @(negedge clk);
      if (rd_read === 1'b1) begin
        idx = rd_index;
        rdr_nreq++;
        d = (rdr_nreq == rdr_miss_at) ? rdr_miss_delay : rdr_delay;
        repeat (d) @(posedge clk);
        #1;
        rd_ovalid = 1'b1;
        rd_data   = elem_of(idx);
        @(posedge clk);
        #1;
        rd_ovalid = 1'b0;
        rd_data   = '0;
      end
    end
  end

  // Reference model: the expected element stream of a sweep.
  logic [31:0]       exp_idx[$];
  logic              exp_last[$];
  logic [ELEMSZ-1:0] exp_data[$];
  logic [31:0]       got_idx[$];
  logic              got_last[$];
  logic [ELEMSZ-1:0] got_data[$];

  task automatic build_model(input logic [31:0] f, input logic [31:0] n);
    exp_idx.delete(); exp_last.delete(); exp_data.delete();
    for (int unsigned i = 0; i < n; i++) begin
      exp_idx.push_back(f + i);
      exp_last.push_back(i == n - 1);
      exp_data.push_back(elem_of(f + i));
    end
  endtask

  task automatic drive_start(input logic [31:0] f, input logic [31:0] n, output int c0);
    @(posedge clk); #1;
    start = 1'b1; first_index = f; count = n; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; first_index = $urandom; count = $urandom;
  endtask

  // Observes the output stream until done or the cycle budget runs out.
  task automatic collect(input int max_cyc, input bit rand_rdy, output bit timed_out,
                         output int done_cyc, output int last_pop, output int n_valid);
    got_idx.delete(); got_last.delete(); got_data.delete();
    timed_out = 1'b1; done_cyc = -1; last_pop = -1; n_valid = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk); #1;
      if (out_valid === 1'b1) n_valid++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_idx.push_back(out_index);
        got_last.push_back(out_last);
        got_data.push_back(out_data);
        last_pop = cyc;
      end
      if (done === 1'b1) begin
        done_cyc = cyc; timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) begin
        out_ready = ($urandom_range(0, 3) != 0);
        rd_iready = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #11;
    n_total++;
    if ({busy, done, rd_read, out_valid, out_last} !== 5'b0)
      $display("FAIL reset_flags: got busy/done/rd_read/out_valid/out_last=%b want 00000",
               {busy, done, rd_read, out_valid, out_last});
    else n_pass++;
    n_total++;
    if (rd_index !== 32'd0) $display("FAIL reset_rd_index: got %h want 0", rd_index);
    else n_pass++;
    n_total++;
    if (out_index !== 32'd0) $display("FAIL reset_out_index: got %h want 0", out_index);
    else n_pass++;
    n_total++;
    if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data);
    else n_pass++;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_hits();
    int c0, dc, lp, nv;
    bit to;
    rdr_delay = 1; salt = $urandom;
    build_model(32'd5, 32'd3);
    drive_start(32'd5, 32'd3, c0);
    collect(40, 1'b0, to, dc, lp, nv);
    n_total++;
    if (to) $display("FAIL hits_timeout: got no done want done within 40 cycles");
    else n_pass++;
    n_total++;
    if (got_idx.size() != 3) $display("FAIL hits_count: got %0d want 3", got_idx.size());
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL hits_elem%0d: got idx=%h last=%b data=%h want idx=%h last=%b data=%h",
                 i, got_idx[i], got_last[i], got_data[i], exp_idx[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
    n_total++;
    if (dc - c0 != 8) $display("FAIL hits_latency: got %0d want 8", dc - c0);
    else n_pass++;
    n_total++;
    if (dc - lp != 1) $display("FAIL hits_done_after_pop: got %0d want 1", dc - lp);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL hits_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_miss();
    int c0, dc, lp, nv, base, nwait, bad;
    bit to, in2, seen;
    rdr_delay = 1; rdr_miss_at = rdr_nreq + 2; rdr_miss_delay = 13; salt = $urandom;
    build_model(32'd5, 32'd3);
    base = req_total; nwait = 0; bad = 0; in2 = 0; seen = 0;
    drive_start(32'd5, 32'd3, c0);
    fork
      collect(80, 1'b0, to, dc, lp, nv);
      for (int c = 0; c < 80 && !seen; c++) begin
        @(negedge clk); #1;
        if (req_total - base == 2) begin
          if (rd_ovalid === 1'b1) seen = 1;
          else begin
            if (in2) begin
              nwait++;
              if (rd_read !== 1'b0 || rd_index !== 32'd6) bad++;
            end
            in2 = 1;
          end
        end
      end
    join
    n_total++;
    if (bad != 0) $display("FAIL miss_hold: got %0d bad WAIT cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (nwait != 12) $display("FAIL miss_wait_len: got %0d want 12", nwait);
    else n_pass++;
    n_total++;
    if (req_total - base != 3) $display("FAIL miss_requests: got %0d want 3", req_total - base);
    else n_pass++;
    n_total++;
    if (to || dc - c0 != 20) $display("FAIL miss_latency: got %0d want 20", dc - c0);
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL miss_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                 i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int c0, dc, lp, nv, base, bad;
    bit to;
    rdr_delay = 1; salt = $urandom; out_ready = 1'b0; bad = 0;
    build_model(32'd40, 32'd4);
    base = req_total;
    drive_start(32'd40, 32'd4, c0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (c >= 8 && rd_read !== 1'b0) bad++;
    end
    n_total++;
    if (req_total - base != 2) $display("FAIL bp_captures: got %0d want 2", req_total - base);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL bp_rd_read_stall: got %0d cycles with rd_read=1 want 0", bad);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b1 || out_index !== 32'd40)
      $display("FAIL bp_head: got valid=%b idx=%h want 1 00000028", out_valid, out_index);
    else n_pass++;
    @(posedge clk); #1; out_ready = 1'b1;
    collect(60, 1'b0, to, dc, lp, nv);
    n_total++;
    if (to || got_idx.size() != 4) $display("FAIL bp_delivered: got %0d want 4", got_idx.size());
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL bp_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                 i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_count_zero();
    int c0, dc, lp, nv, base;
    bit to;
    base = req_total;
    drive_start(32'd77, 32'd0, c0);
    collect(20, 1'b0, to, dc, lp, nv);
    n_total++;
    if (to || dc - c0 != 2) $display("FAIL zero_done_cycle: got %0d want 2", dc - c0);
    else n_pass++;
    n_total++;
    if (nv != 0 || req_total != base)
      $display("FAIL zero_no_output: got valid_cycles=%0d requests=%0d want 0 0", nv, req_total - base);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int c0, dc, lp, nv;
    bit to;
    rdr_delay = $urandom_range(1, 3); salt = $urandom;
    build_model(32'hFFFF_FFFF, 32'd2);
    drive_start(32'hFFFF_FFFF, 32'd2, c0);
    collect(40, 1'b0, to, dc, lp, nv);
    n_total++;
    if (to || got_idx.size() != 2) $display("FAIL wrap_count: got %0d want 2", got_idx.size());
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL wrap_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                 i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_start_busy();
    int c0, dc, lp, nv, base;
    bit to;
    rdr_delay = 2; salt = $urandom;
    build_model(32'd20, 32'd3);
    base = req_total;
    drive_start(32'd20, 32'd3, c0);
    fork
      collect(60, 1'b0, to, dc, lp, nv);
      begin
        repeat (2) @(posedge clk);
        #1; start = 1'b1; first_index = 32'd999; count = 32'd7;
        @(posedge clk);
        #1; start = 1'b0;
      end
    join
    n_total++;
    if (to || got_idx.size() != 3) $display("FAIL busy_count: got %0d want 3", got_idx.size());
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL busy_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                 i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
    repeat (5) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || req_total - base != 3)
      $display("FAIL busy_ignored: got busy=%b requests=%0d want 0 3", busy, req_total - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0, dc, lp, nv, base, bad;
    bit to;
    rdr_delay = 1; rdr_miss_at = rdr_nreq + 2; rdr_miss_delay = 20; salt = $urandom;
    out_ready = 1'b0; base = req_total; bad = 0;
    drive_start(32'd100, 32'd5, c0);
    for (int c = 0; c < 40 && (req_total - base) < 2; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2; resetn = 1'b0;
    #1;
    n_total++;
    if ({busy, done, rd_read, out_valid, out_last} !== 5'b0 || rd_index !== 32'd0 ||
        out_index !== 32'd0 || out_data !== '0)
      $display("FAIL rstmid_outputs: got busy=%b done=%b rd_read=%b valid=%b last=%b rd_index=%h out_index=%h want all 0",
               busy, done, rd_read, out_valid, out_last, rd_index, out_index);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rstmid_late_response: got %0d active cycles want 0", bad);
    else n_pass++;
    build_model(32'd200, 32'd2);
    drive_start(32'd200, 32'd2, c0);
    collect(40, 1'b0, to, dc, lp, nv);
    n_total++;
    if (to || got_idx.size() != 2 || dc - c0 != 6)
      $display("FAIL rstmid_restart: got count=%0d latency=%0d want 2 6", got_idx.size(), dc - c0);
    else n_pass++;
    for (int i = 0; i < exp_idx.size(); i++) begin
      n_total++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
        $display("FAIL rstmid_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                 i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int c0, dc, lp, nv;
    bit to;
    logic [31:0] f, n;
    for (int s = 0; s < 6; s++) begin
      f = (s % 2 == 0) ? $urandom : (32'hFFFF_FFFF - $urandom_range(0, 3));
      n = $urandom_range(1, 6);
      rdr_delay = $urandom_range(1, 4); salt = $urandom;
      build_model(f, n);
      drive_start(f, n, c0);
      collect(300, 1'b1, to, dc, lp, nv);
      @(posedge clk); #1; out_ready = 1'b1; rd_iready = 1'b1;
      n_total++;
      if (to || got_idx.size() != exp_idx.size())
        $display("FAIL rand%0d_count: got %0d want %0d", s, got_idx.size(), exp_idx.size());
      else n_pass++;
      for (int i = 0; i < exp_idx.size(); i++) begin
        n_total++;
        if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_last[i] !== exp_last[i] || got_data[i] !== exp_data[i])
          $display("FAIL rand%0d_elem%0d: got idx=%h last=%b want idx=%h last=%b",
                   s, i, got_idx[i], got_last[i], exp_idx[i], exp_last[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_backpressure();
    test_count_zero();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tri_fetch_seq.md
# tri_fetch_seq

Upstream sequencer for the cached element reader. On a start command it sweeps element indices `first_index` to `first_index+count-1`. For each index it issues one read to the reader, captures the `ELEMSZ`-bit element when the reader signals valid, and forwards the element downstream through a small FIFO with valid/ready flow control. It feeds the triangle/intersection stage.

## Interface
- `NDWORDS`, 9: 32-bit words per element.
- `ELEMSZ`, 32*NDWORDS: element width in bits.
- `FIFO_DEPTH`, 2: output FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `first_index`  in  32  first element index. Sampled with `start`.
- `count`  in  32  number of elements. Sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last element has left the FIFO.
- `rd_index`  out  32  index presented to the reader.
- `rd_read`  out  1  read request (the reader's ivalid).
- `rd_iready`  in  1  reader can accept a request.
- `rd_data`  in  ELEMSZ  element from the reader.
- `rd_ovalid`  in  1  `rd_data` is valid.
- `out_data`  out  ELEMSZ  FIFO head element.
- `out_index`  out  32  index of the head element.
- `out_last`  out  1  head element is the last one of the sweep.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  downstream accepts the head element.

## Operation
- Reset values: `busy=0`, `done=0`, `rd_read=0`, `rd_index=0`, `out_valid=0`, `out_last=0`. `out_data` and `out_index` read as 0. FIFO is empty. State is IDLE.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - On `start`, latch `cur_idx=first_index` and `remaining=count`.
  - If `count==0`, go to DRAIN; otherwise go to ISSUE.
- ISSUE:
  - `rd_read=1` only when `rd_iready=1` and `fifo_count + 1 ≤ FIFO_DEPTH`, so a slot is reserved for the request in flight.
  - On a cycle where `rd_read=1`, go to WAIT.
  - `rd_read` is combinational from state, `rd_iready` and FIFO occupancy.
  - `rd_index` is registered and always equals `cur_idx`.
- WAIT:
  - `rd_read=0`. `rd_index` is held stable until capture.
  - On `rd_ovalid`, write `{rd_data, cur_idx, remaining==1}` into the FIFO, then `cur_idx+=1` (wraps mod 2^32) and `remaining-=1`.
  - Next state: ISSUE if `remaining>1` before the decrement, else DRAIN.
- DRAIN:
  - When the FIFO is empty (including the `count==0` case), pulse `done` for one cycle and go to IDLE.
- Only one request is ever outstanding. `rd_ovalid` outside WAIT is ignored.
- FIFO:
  - A push occurs on capture; a pop occurs on `out_valid && out_ready`.
  - Simultaneous push and pop when full is legal, because the slot reservation guarantees no overflow.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
- `start` while `busy` is ignored. `first_index`/`count` changes mid-sweep have no effect.
- Asynchronous reset mid-sweep:
  - All state returns to reset values immediately and FIFO contents are discarded.
  - An outstanding reader response after reset is ignored (the block is in IDLE).

## Timing
- `start` at cycle 0 gives ISSUE at cycle 1 and `rd_read` at cycle 1 if `rd_iready` is high.
- Cache hit: `rd_ovalid` at cycle 2, FIFO write at the cycle-2 edge, `out_valid=1` at cycle 3.
- Steady-state hit throughput is one element per 2 cycles (ISSUE, WAIT), with `out_ready` held high.
- On a miss, WAIT lasts until `rd_ovalid`. There is no timeout.
- `done` rises one cycle after the pop of the `out_last` element.
- For `count==0`, `done` is high at cycle 2 after `start` at cycle 0.

## Structure
- Package `tri_fetch_pkg`:
  - FSM state enum `tri_fetch_state_t`.
  - FIFO entry struct `{ELEMSZ data, 32 index, 1 last}`.
  - Default `NDWORDS`/`FIFO_DEPTH` localparams.
- One sub-module, `sync_fifo`:
  - Generic width/depth.
  - Registered head output, `count` output, asynchronous active-low reset.
- Top level holds the FSM, counters and slot-reservation logic.

## Test plan
- Hits, `out_ready=1`: `first_index=5`, `count=3`, reader answers `rd_ovalid` one cycle after each `rd_read`.
  - Required: `out_index` = 5, 6, 7 on consecutive accepts, `out_last` only on index 7.
  - Required: `done` one cycle after the index-7 pop; total time from `start` to `done` is 8 cycles.
- Miss: second read answered 12 cycles late.
  - Required: `rd_index=6` and `rd_read=0` held throughout WAIT; no duplicate request.
- Backpressure: `out_ready=0` with `count=4`.
  - Required: exactly 2 captures, then `rd_read` stays 0.
  - Required: after `out_ready=1`, all 4 elements are delivered in order with no loss.
- Boundary values:
  - `count=0`: `done` at cycle 2, `out_valid` never asserted.
  - `first_index=32'hFFFFFFFF`, `count=2`: `out_index` = FFFFFFFF then 0.
- Reset and ignored inputs:
  - `resetn` low during WAIT of a 5-element sweep: outputs return to reset values asynchronously.
  - A late `rd_ovalid` is ignored and a new `start` works normally.
  - `start` pulsed while `busy` has no effect.
